// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit owning the HI/LO register pair.
//
// Executes MULT/MULTU/DIV/DIVU on the rs/rt operands, accepts MTHI/MTLO writes
// and drives Hi/Lo back to the datapath for MFHI/MFLO. Busy asks control to
// stall any HI/LO access until the result has been committed.
//
// Ports:
//   Clk      in   clock, all state updates on the rising edge
//   Reset    in   asynchronous, active-high reset
//   Start    in   begin operation (sampled only when idle)
//   MDOp     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B     in   rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   MTHI     in   write WData to Hi (idle only)
//   MTLO     in   write WData to Lo (idle only)
//   WData    in   MTHI/MTLO data
//   Busy     out  operation in progress (stays high through the Done cycle)
//   Done     out  one-cycle pulse, Hi/Lo just committed
//   DivZero  out  one-cycle pulse with Done on divide by zero
//   Hi, Lo   out  HI / LO registers
//
// Configuration macro: MULDIV_FAST_MULT_EN
//   defined   : MULT/MULTU use a combinational WIDTH x WIDTH multiplier and
//               finish in one RUN cycle (Done after edge 2).
//   undefined : shift-add multiply, one bit per cycle (Done after edge WIDTH+1).
//   Divide is always restoring, one bit per cycle.

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MTHI,
  input  logic             MTLO,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            dz;

  // Working registers: data only, never reset.
  logic [1:0]       op;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mcand;   // |A| for multiply, |B| (divisor) for divide
  logic [WIDTH-1:0] acc_hi;  // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;  // multiplier shifting out / dividend->quotient

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  logic             is_signed;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             accept;

  assign is_signed = ~MDOp[0];
  assign abs_a     = abs_val(A, is_signed);
  assign abs_b     = abs_val(B, is_signed);
  assign accept    = (state == IDLE) && !Busy && Start;

  // Step datapath: one shift-add or one restoring-subtract bit per cycle.
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_sh;
  logic [WIDTH:0] div_diff;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  // The partial remainder is always below the divisor, so div_diff[WIDTH]
  // is exactly the borrow of the trial subtraction.
  assign div_diff = div_sh - {1'b0, mcand};

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mcand} * {{WIDTH{1'b0}}, acc_lo};
`endif

  // Sign correction applied on commit.
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_res;
  logic [WIDTH-1:0]   rem_res;

  assign prod_res = cond_neg2({acc_hi, acc_lo}, sign_a ^ sign_b);
  assign quot_res = cond_neg(acc_lo, sign_a ^ sign_b);
  assign rem_res  = cond_neg(acc_hi, sign_a);

  // ---- Stage: operand capture and iteration ----
  always_ff @(posedge Clk) begin
    if (accept) begin
      op     <= MDOp;
      sign_a <= is_signed & A[WIDTH-1];
      sign_b <= is_signed & B[WIDTH-1];
      mcand  <= MDOp[1] ? abs_b : abs_a;
      acc_lo <= MDOp[1] ? abs_a : abs_b;
      acc_hi <= '0;
    end else if (state == RUN) begin
      if (op[1]) begin
        if (!div_diff[WIDTH]) begin
          acc_hi <= div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= div_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
`ifdef MULDIV_FAST_MULT_EN
        {acc_hi, acc_lo} <= fast_prod;
`else
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
`endif
      end
    end
  end

  // ---- Stage: control FSM and HI/LO commit ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      count   <= '0;
      dz      <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      // Busy covers the Done cycle so a Start arriving with Done is ignored.
      if (Done) Busy <= 1'b0;
      case (state)
        IDLE: begin
          if (!Busy) begin
            if (Start) begin
              Busy  <= 1'b1;
              count <= '0;
              if (MDOp[1] && (B == '0)) begin
                dz    <= 1'b1;
                state <= FIN;
              end else begin
                dz    <= 1'b0;
                state <= RUN;
              end
            end else begin
              if (MTHI) Hi <= WData;
              if (MTLO) Lo <= WData;
            end
          end
        end
        RUN: begin
          count <= count + CW'(1);
`ifdef MULDIV_FAST_MULT_EN
          if (!op[1] || (count == CW'(WIDTH - 1))) state <= FIN;
`else
          if (count == CW'(WIDTH - 1)) state <= FIN;
`endif
        end
        FIN: begin
          state   <= IDLE;
          Done    <= 1'b1;
          DivZero <= dz;
          if (!dz) begin
            if (op[1]) begin
              Hi <= rem_res;
              Lo <= quot_res;
            end else begin
              Hi <= prod_res[2*WIDTH-1:WIDTH];
              Lo <= prod_res[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32).

module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic [1:0]   MDOp;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         MTHI;
  logic         MTLO;
  logic [W-1:0] WData;
  logic         Busy;
  logic         Done;
  logic         DivZero;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .MTHI(MTHI), .MTLO(MTLO), .WData(WData), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue an op (Start sampled at the next edge = edge 0) and wait for Done.
  // lat = edge number after which Done was seen, or -1 on timeout.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat, output logic dz);
    Start = 1'b1; MDOp = op; A = a; B = b;
    tick();
    Start = 1'b0;
    lat = -1;
    dz  = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (Done === 1'b1) begin
        lat = n;
        dz  = DivZero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; MDOp = 2'b00; A = '0; B = '0;
    MTHI = 1'b0; MTLO = 1'b0; WData = '0;
    tick(); tick();
    checks++;
    if ({Busy, Done, DivZero} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {Busy, Done, DivZero});
    end
    checks++;
    if ({Hi, Lo} !== 64'h0) begin
      errors++; $display("FAIL reset_hilo: got %h expected 0", {Hi, Lo});
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_multu();
    int done_at = -1;
    int done_cnt = 0;
    int busy_bad = 0;
    logic [W-1:0] hi_d, lo_d;
    Start = 1'b1; MDOp = 2'b01; A = 32'hFFFFFFFF; B = 32'd2;
    tick();
    Start = 1'b0;
    hi_d = '0; lo_d = '0;
    for (int n = 1; n <= MUL_LAT + 3; n++) begin
      tick();
      if (n <= MUL_LAT && Busy !== 1'b1) busy_bad++;
      if (n > MUL_LAT && Busy !== 1'b0) busy_bad++;
      if (n < MUL_LAT && {Hi, Lo} !== 64'h0) busy_bad++;
      if (Done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin done_at = n; hi_d = Hi; lo_d = Lo; end
      end
    end
    checks++;
    if (done_at !== MUL_LAT) begin
      errors++; $display("FAIL multu_latency: got %0d expected %0d", done_at, MUL_LAT);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL multu_done_pulse: got %0d cycles expected 1", done_cnt);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++; $display("FAIL multu_busy_hold: got %0d bad cycles expected 0", busy_bad);
    end
    checks++;
    if ({hi_d, lo_d} !== 64'h00000001_FFFFFFFE) begin
      errors++; $display("FAIL multu_result: got %h expected 00000001fffffffe", {hi_d, lo_d});
    end
  endtask

  task automatic test_mult_signed();
    int lat; logic dz;
    do_op(2'b00, 32'hFFFFFFFD, 32'd7, lat, dz);
    checks++;
    if (lat !== MUL_LAT || {Hi, Lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      errors++; $display("FAIL mult_neg: got lat %0d %h expected lat %0d ffffffffffffffeb", lat, {Hi, Lo}, MUL_LAT);
    end
    tick();
    do_op(2'b00, 32'h80000000, 32'h80000000, lat, dz);
    checks++;
    if (lat !== MUL_LAT || {Hi, Lo} !== 64'h40000000_00000000) begin
      errors++; $display("FAIL mult_minmin: got lat %0d %h expected lat %0d 4000000000000000", lat, {Hi, Lo}, MUL_LAT);
    end
    tick();
  endtask

  task automatic test_div();
    int lat; logic dz;
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, dz);
    checks++;
    if (lat !== DIV_LAT || Lo !== 32'hFFFFFFFD || Hi !== 32'hFFFFFFFF || dz !== 1'b0) begin
      errors++; $display("FAIL div_neg7_2: got lat %0d lo %h hi %h dz %b expected lat %0d lo fffffffd hi ffffffff dz 0", lat, Lo, Hi, dz, DIV_LAT);
    end
    tick();
    do_op(2'b10, 32'd7, 32'hFFFFFFFE, lat, dz);
    checks++;
    if (Lo !== 32'hFFFFFFFD || Hi !== 32'h00000001) begin
      errors++; $display("FAIL div_7_neg2: got lo %h hi %h expected lo fffffffd hi 00000001", Lo, Hi);
    end
    tick();
    do_op(2'b11, 32'd100, 32'd7, lat, dz);
    checks++;
    if (lat !== DIV_LAT || Lo !== 32'd14 || Hi !== 32'd2) begin
      errors++; $display("FAIL divu_100_7: got lat %0d lo %h hi %h expected lat %0d lo 0000000e hi 00000002", lat, Lo, Hi, DIV_LAT);
    end
    tick();
    do_op(2'b11, 32'hFFFFFFFF, 32'h10, lat, dz);
    checks++;
    if (Lo !== 32'h0FFFFFFF || Hi !== 32'h0000000F) begin
      errors++; $display("FAIL divu_big: got lo %h hi %h expected lo 0fffffff hi 0000000f", Lo, Hi);
    end
    tick();
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, dz);
    checks++;
    if (Lo !== 32'h80000000 || Hi !== 32'h0) begin
      errors++; $display("FAIL div_overflow: got lo %h hi %h expected lo 80000000 hi 00000000", Lo, Hi);
    end
    tick();
  endtask

  task automatic test_mt_divzero();
    int lat; logic dz;
    MTHI = 1'b1; WData = 32'h11; tick();
    MTHI = 1'b0; MTLO = 1'b1; WData = 32'h22; tick();
    MTLO = 1'b0;
    checks++;
    if (Hi !== 32'h11 || Lo !== 32'h22) begin
      errors++; $display("FAIL mthi_mtlo: got hi %h lo %h expected hi 00000011 lo 00000022", Hi, Lo);
    end
    do_op(2'b10, 32'd5, 32'd0, lat, dz);
    checks++;
    if (lat !== 1 || dz !== 1'b1) begin
      errors++; $display("FAIL divzero_flag: got lat %0d dz %b expected lat 1 dz 1", lat, dz);
    end
    checks++;
    if (Hi !== 32'h11 || Lo !== 32'h22) begin
      errors++; $display("FAIL divzero_hold: got hi %h lo %h expected hi 00000011 lo 00000022", Hi, Lo);
    end
    tick();
    checks++;
    if (Busy !== 1'b0 || DivZero !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL divzero_release: got busy %b dz %b done %b expected 0 0 0", Busy, DivZero, Done);
    end
    MTHI = 1'b1; MTLO = 1'b1; WData = 32'h33; tick();
    MTHI = 1'b0; MTLO = 1'b0;
    checks++;
    if (Hi !== 32'h33 || Lo !== 32'h33) begin
      errors++; $display("FAIL mt_both: got hi %h lo %h expected hi 00000033 lo 00000033", Hi, Lo);
    end
    // Start together with MTHI: the MT write is dropped.
    MTHI = 1'b1; WData = 32'h99;
    Start = 1'b1; MDOp = 2'b01; A = 32'd3; B = 32'd4;
    tick();
    Start = 1'b0; MTHI = 1'b0;
    checks++;
    if (Hi !== 32'h33 || Busy !== 1'b1) begin
      errors++; $display("FAIL start_beats_mt: got hi %h busy %b expected hi 00000033 busy 1", Hi, Busy);
    end
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (Done === 1'b1) begin lat = n; break; end
    end
    checks++;
    if (lat !== MUL_LAT || Hi !== 32'h0 || Lo !== 32'd12) begin
      errors++; $display("FAIL start_mt_result: got lat %0d hi %h lo %h expected lat %0d hi 0 lo 0000000c", lat, Hi, Lo, MUL_LAT);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int lat = -1;
    int extra = 0;
    Start = 1'b1; MDOp = 2'b01; A = 32'h10; B = 32'h10;
    tick();
    Start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (n == 1) begin
        Start = 1'b1; MDOp = 2'b11; A = 32'd1000; B = 32'd3;
        MTHI = 1'b1; WData = 32'h55;
      end
      tick();
      Start = 1'b0; MTHI = 1'b0;
      if (Done === 1'b1) begin lat = n; break; end
    end
    checks++;
    if (lat !== MUL_LAT || Hi !== 32'h0 || Lo !== 32'h100) begin
      errors++; $display("FAIL busy_ignore: got lat %0d hi %h lo %h expected lat %0d hi 0 lo 00000100", lat, Hi, Lo, MUL_LAT);
    end
    // Start in the Done cycle must be ignored.
    Start = 1'b1; MDOp = 2'b01; A = 32'd5; B = 32'd5;
    tick();
    Start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (Busy !== 1'b0 || Done !== 1'b0) extra++;
      tick();
    end
    checks++;
    if (extra !== 0 || Lo !== 32'h100) begin
      errors++; $display("FAIL start_on_done: got %0d busy cycles lo %h expected 0 cycles lo 00000100", extra, Lo);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic dz;
    Start = 1'b1; MDOp = 2'b01; A = 32'd9; B = 32'd9;
    tick();
    Start = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0 || Done !== 1'b0) begin
      errors++; $display("FAIL reset_async: got busy %b hi %h lo %h done %b expected 0 0 0 0", Busy, Hi, Lo, Done);
    end
    tick();
    Reset = 1'b0;
    tick();
    do_op(2'b11, 32'd100, 32'd7, lat, dz);
    checks++;
    if (lat !== DIV_LAT || Lo !== 32'd14 || Hi !== 32'd2) begin
      errors++; $display("FAIL after_reset_op: got lat %0d lo %h hi %h expected lat %0d lo 0000000e hi 00000002", lat, Lo, Hi, DIV_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
    test_div();
    test_mt_divzero();
    test_busy_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
